// File: rtl/uart_rx_deserializer_pkg.sv
// Shared definitions for the UART receive deserializer: FSM state encodings,
// bit-order and FIFO-level names, and the expected-parity helper.
package uart_rx_deserializer_pkg;

    localparam int FIFO_W = 8;

    // One-hot encodings, shared with the TX FSM
    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        STARTBIT  = 5'b00010,
        DATABITS  = 5'b00100,
        PARITYBIT = 5'b01000,
        STOPBIT   = 5'b10000
    } rxState_t;

    localparam logic BIGEND    = 1'b1;
    localparam logic LITTLEEND = 1'b0;
    localparam logic EMPTY     = 1'b1;
    localparam logic NONEMPTY  = 1'b0;

    // Parity bit the transmitter must have sent for this data (zero-extended)
    function automatic logic expectedParity(input logic [FIFO_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// RX FIFO side of the deserializer: write strobe, byte, full flag and per-frame status pulses.
interface uart_rx_deserializer_if
    import uart_rx_deserializer_pkg::*;
    ;
    logic              p_FifoFull_i;
    logic              n_FifoWe_o;
    logic [FIFO_W-1:0] FifoData_o;
    logic              p_ParityErr_o;
    logic              p_FrameErr_o;
    logic              p_Overrun_o;

    modport master (
        input  p_FifoFull_i,
        output n_FifoWe_o, FifoData_o, p_ParityErr_o, p_FrameErr_o, p_Overrun_o
    );

    modport slave (
        output p_FifoFull_i,
        input  n_FifoWe_o, FifoData_o, p_ParityErr_o, p_FrameErr_o, p_Overrun_o
    );
endinterface

// File: rtl/uart_rx_deserializer_sync.sv
// Serial-line synchronizer plus tick-paced falling-edge detector for start-bit search.
module uart_rx_deserializer_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic rxIn,
    output logic rxS,
    output logic fallEdge
);
    logic [SYNC_STAGES-1:0] syncR;
    logic                   rxPrev;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncR  <= '1;
            rxPrev <= 1'b1;
        end else begin
            syncR <= {syncR[SYNC_STAGES-2:0], rxIn};
            if (tick) rxPrev <= rxS;
        end
    end

    assign rxS      = syncR[SYNC_STAGES-1];
    // A line that is already low when we look (break) never produces an edge
    assign fallEdge = rxPrev & ~rxS;
endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive FSM: qualifies start bits, deserializes data bits in either order,
// checks parity and stop bit, and writes good bytes to the RX FIFO.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p_SampleSig_i,
    input  logic                   RxData_i,
    input  logic                   p_BigEnd_i,
    input  logic                   p_ParityEn_i,
    input  logic                   p_ParityOdd_i,
    uart_rx_deserializer_if.master fifo,
    output logic [4:0]             State_o
);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SCW-1:0] HALF_M1 = SCW'(OVERSAMPLE/2 - 1);
    localparam logic [SCW-1:0] FULL_M1 = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    rxState_t             state, stateN;
    logic [SCW-1:0]       sampleCnt, sampleCntN;
    logic [BCW-1:0]       bitCnt, bitCntN;
    logic [DATA_BITS-1:0] shiftR, shiftN;
    logic                 parBad, parBadN;
    logic                 bigEnd, bigEndN, parEn, parEnN, parOdd, parOddN;
    logic                 stopDone;
    logic                 rxS, fallEdge;

    uart_rx_deserializer_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .clk      (clk),
        .rst      (rst),
        .tick     (p_SampleSig_i),
        .rxIn     (RxData_i),
        .rxS      (rxS),
        .fallEdge (fallEdge)
    );

    always_comb begin
        stateN     = state;
        sampleCntN = sampleCnt;
        bitCntN    = bitCnt;
        shiftN     = shiftR;
        parBadN    = parBad;
        bigEndN    = bigEnd;
        parEnN     = parEn;
        parOddN    = parOdd;
        stopDone   = 1'b0;
        if (p_SampleSig_i) begin
            unique case (state)
                IDLE: if (fallEdge) begin
                    stateN     = STARTBIT;
                    sampleCntN = '0;
                end
                STARTBIT: if (sampleCnt == HALF_M1) begin
                    if (rxS) begin
                        stateN = IDLE;
                    end else begin
                        stateN     = DATABITS;
                        sampleCntN = '0;
                        bitCntN    = '0;
                        parBadN    = 1'b0;
                        bigEndN    = p_BigEnd_i;
                        parEnN     = p_ParityEn_i;
                        parOddN    = p_ParityOdd_i;
                    end
                end else begin
                    sampleCntN = sampleCnt + 1'b1;
                end
                DATABITS: if (sampleCnt == FULL_M1) begin
                    sampleCntN = '0;
                    if (bigEnd == BIGEND) shiftN = {shiftR[DATA_BITS-2:0], rxS};
                    else                  shiftN = {rxS, shiftR[DATA_BITS-1:1]};
                    if (bitCnt == LAST_BIT) stateN = parEn ? PARITYBIT : STOPBIT;
                    else                    bitCntN = bitCnt + 1'b1;
                end else begin
                    sampleCntN = sampleCnt + 1'b1;
                end
                PARITYBIT: if (sampleCnt == FULL_M1) begin
                    sampleCntN = '0;
                    parBadN    = rxS != expectedParity(FIFO_W'(shiftR), parOdd);
                    stateN     = STOPBIT;
                end else begin
                    sampleCntN = sampleCnt + 1'b1;
                end
                STOPBIT: if (sampleCnt == FULL_M1) begin
                    sampleCntN = '0;
                    stopDone   = 1'b1;
                    stateN     = IDLE;
                end else begin
                    sampleCntN = sampleCnt + 1'b1;
                end
                default: stateN = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sampleCnt <= '0;
            bitCnt    <= '0;
            parBad    <= 1'b0;
            bigEnd    <= LITTLEEND;
            parEn     <= 1'b0;
            parOdd    <= 1'b0;
        end else begin
            state     <= stateN;
            sampleCnt <= sampleCntN;
            bitCnt    <= bitCntN;
            parBad    <= parBadN;
            bigEnd    <= bigEndN;
            parEn     <= parEnN;
            parOdd    <= parOddN;
        end
    end

    always_ff @(posedge clk) shiftR <= shiftN;

    // Frame outcome is registered: strobes appear one clk after the stop-bit sample
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo.n_FifoWe_o    <= 1'b1;
            fifo.FifoData_o    <= '0;
            fifo.p_ParityErr_o <= 1'b0;
            fifo.p_FrameErr_o  <= 1'b0;
            fifo.p_Overrun_o   <= 1'b0;
        end else begin
            fifo.n_FifoWe_o    <= 1'b1;
            fifo.p_ParityErr_o <= 1'b0;
            fifo.p_FrameErr_o  <= 1'b0;
            fifo.p_Overrun_o   <= 1'b0;
            if (stopDone) begin
                if (!rxS) begin
                    fifo.p_FrameErr_o <= 1'b1;
                end else if (fifo.p_FifoFull_i) begin
                    fifo.p_Overrun_o <= 1'b1;
                end else begin
                    fifo.n_FifoWe_o    <= 1'b0;
                    fifo.FifoData_o    <= FIFO_W'(shiftR);
                    fifo.p_ParityErr_o <= parBad;
                end
            end
        end
    end

    assign State_o = state;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven bit by bit, a frame-level
// model predicts each outcome, and a per-cycle compare process checks the FIFO side.
module tb_uart_rx_deserializer;
    import uart_rx_deserializer_pkg::*;

    localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic rxLine = 1'b1;
    logic bigEndIn = 1'b0, parEnIn = 1'b0, parOddIn = 1'b0;
    logic [4:0] stateOut;
    int   tickDiv = 0;

    uart_rx_deserializer_if ifc ();

    uart_rx_deserializer dut (
        .clk           (clk),
        .rst           (rst),
        .p_SampleSig_i (tick),
        .RxData_i      (rxLine),
        .p_BigEnd_i    (bigEndIn),
        .p_ParityEn_i  (parEnIn),
        .p_ParityOdd_i (parOddIn),
        .fifo          (ifc.master),
        .State_o       (stateOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tickDiv = (tickDiv + 1) % 4;
        tick = (tickDiv == 0);
    end

    typedef struct {
        int         kind;   // 0 write, 1 frame error, 2 overrun
        logic [7:0] data;
        bit         par;
    } ev_t;

    ev_t        expQ[$];
    int         passCnt = 0, totalCnt = 0;
    int         writes = 0, frameErrs = 0, overruns = 0;
    logic [7:0] modelData = 8'h00;
    logic [7:0] lastWrData = 8'h00;
    bit         lastWrPar = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level outcome straight from the framing rules
    function automatic ev_t predict(input logic [7:0] d, input bit pen, input bit podd,
                                    input bit pbit, input bit stop, input bit full);
        ev_t e;
        int  ones;
        e.data = d;
        e.par  = 1'b0;
        if (!stop)     e.kind = 1;
        else if (full) e.kind = 2;
        else begin
            e.kind = 0;
            ones = $countones(d) + int'(pbit);
            if (pen) e.par = podd ? (ones % 2 == 0) : (ones % 2 == 1);
        end
        return e;
    endfunction

    always @(posedge clk) if (rst) modelData = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (!ifc.n_FifoWe_o || ifc.p_FrameErr_o || ifc.p_Overrun_o || ifc.p_ParityErr_o) begin
                if (expQ.size() == 0) begin
                    check("unexpected-event", 1, 0);
                end else begin
                    ev_t e;
                    e = expQ.pop_front();
                    check("write-strobe", {31'd0, !ifc.n_FifoWe_o}, {31'd0, e.kind == 0});
                    check("frame-err", {31'd0, ifc.p_FrameErr_o}, {31'd0, e.kind == 1});
                    check("overrun", {31'd0, ifc.p_Overrun_o}, {31'd0, e.kind == 2});
                    check("parity-err", {31'd0, ifc.p_ParityErr_o}, {31'd0, e.par});
                    if (e.kind == 0) begin
                        check("write-data", {24'd0, ifc.FifoData_o}, {24'd0, e.data});
                        modelData  = e.data;
                        lastWrData = ifc.FifoData_o;
                        lastWrPar  = ifc.p_ParityErr_o;
                        writes++;
                    end else if (e.kind == 1) frameErrs++;
                    else overruns++;
                end
            end else begin
                check("data-hold", {24'd0, ifc.FifoData_o}, {24'd0, modelData});
            end
        end
    end

    task automatic holdLine(input logic v, input int clks);
        rxLine = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit big, input bit pen, input bit podd,
                             input bit pbit, input bit stop, input bit full);
        bigEndIn = big;
        parEnIn  = pen;
        parOddIn = podd;
        ifc.p_FifoFull_i = full;
        expQ.push_back(predict(d, pen, podd, pbit, stop, full));
        holdLine(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) holdLine(big ? d[7-i] : d[i], BIT_CLK);
        if (pen) holdLine(pbit, BIT_CLK);
        holdLine(stop, BIT_CLK);
        check("event-by-stop-end", expQ.size(), 0);
        expQ.delete();
        ifc.p_FifoFull_i = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        ifc.p_FifoFull_i = 1'b0;
        repeat (4) @(negedge clk);
        check("reset-state", {27'd0, stateOut}, 32'h1);
        check("reset-we", {31'd0, ifc.n_FifoWe_o}, 1);
        check("reset-data", {24'd0, ifc.FifoData_o}, 0);
        check("reset-flags", {29'd0, ifc.p_ParityErr_o, ifc.p_FrameErr_o, ifc.p_Overrun_o}, 0);
        rst = 1'b0;
        holdLine(1'b1, 2 * BIT_CLK);

        // 1: LSB first 0xA5, even parity bit 0 is correct
        sendFrame(8'hA5, 0, 1, 0, 0, 1, 0);
        check("t1-data", {24'd0, lastWrData}, 32'hA5);
        check("t1-par", {31'd0, lastWrPar}, 0);
        check("t1-writes", writes, 1);

        // 2: MSB first 0x3C, no parity
        sendFrame(8'h3C, 1, 0, 0, 0, 1, 0);
        check("t2-data", {24'd0, lastWrData}, 32'h3C);
        check("t2-writes", writes, 2);

        // 3: 0x01 needs even parity bit 1; sending 0 flags a parity error
        sendFrame(8'h01, 0, 1, 0, 0, 1, 0);
        check("t3-data", {24'd0, lastWrData}, 32'h01);
        check("t3-par", {31'd0, lastWrPar}, 1);

        // 4: bad stop bit, line stays low, then recovers for 0x12
        sendFrame(8'h55, 0, 0, 0, 0, 0, 0);
        holdLine(1'b0, 3 * BIT_CLK);
        check("t4-break-idle", {27'd0, stateOut}, 32'h1);
        holdLine(1'b1, 2 * BIT_CLK);
        sendFrame(8'h12, 0, 0, 0, 0, 1, 0);
        check("t4-frameerrs", frameErrs, 1);
        check("t4-data", {24'd0, lastWrData}, 32'h12);
        check("t4-writes", writes, 4);

        // 5: glitch of 4 ticks is a false start; then a frame into a full FIFO
        holdLine(1'b0, 16);
        holdLine(1'b1, 3 * BIT_CLK);
        check("t5-false-start", {27'd0, stateOut}, 32'h1);
        check("t5-no-write", writes, 4);
        sendFrame(8'h77, 0, 0, 0, 0, 1, 1);
        check("t5-overruns", overruns, 1);
        check("t5-writes", writes, 4);
        check("t5-data-held", {24'd0, ifc.FifoData_o}, 32'h12);
        holdLine(1'b1, BIT_CLK);

        // 6: reset during data bit 3, then a clean MSB-first odd-parity 0xC3
        bigEndIn = 0;
        parEnIn  = 0;
        holdLine(1'b0, BIT_CLK);
        holdLine(1'b1, BIT_CLK);
        holdLine(1'b1, BIT_CLK);
        holdLine(1'b0, BIT_CLK);
        holdLine(1'b0, BIT_CLK / 2);
        rst = 1'b1;
        rxLine = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6-reset-state", {27'd0, stateOut}, 32'h1);
        check("t6-reset-we", {31'd0, ifc.n_FifoWe_o}, 1);
        check("t6-reset-data", {24'd0, ifc.FifoData_o}, 0);
        holdLine(1'b1, 3 * BIT_CLK);
        check("t6-no-write", writes, 4);
        sendFrame(8'hC3, 1, 1, 1, 1, 1, 0);
        check("t6-data", {24'd0, lastWrData}, 32'hC3);
        check("t6-par", {31'd0, lastWrPar}, 0);
        check("t6-writes", writes, 5);
        holdLine(1'b1, BIT_CLK);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
